// File: rtl/m31_pkg.sv
// M31 (p = 2^31-1) field types, opcodes and reduction helpers shared by the
// scalar add/mul blocks and the vector ALU.
package m31_pkg;

    typedef logic [30:0] m31_t;

    localparam m31_t P_M31 = 31'h7FFFFFFF;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_MAC = 2'd3
    } m31_op_e;

    typedef struct packed {
        m31_t a;
        m31_t b;
        m31_t c;
    } m31_opnd_t;

    // 2^31 == 1 mod p, so the carry folds back in; a second fold covers the
    // single case where the first fold itself carries out.
    function automatic m31_t m31_fold32(input logic [31:0] x);
        logic [31:0] t;
        m31_t        u;
        t = {1'b0, x[30:0]} + {31'b0, x[31]};
        u = t[30:0] + {30'b0, t[31]};
        return (u == P_M31) ? '0 : u;
    endfunction

    function automatic m31_t m31_fold62(input logic [61:0] x);
        logic [31:0] t;
        t = {1'b0, x[30:0]} + {1'b0, x[61:31]};
        return m31_fold32(t);
    endfunction

endpackage

// File: rtl/m31_vec_lane.sv
// One M31 lane: capture, raw add/sub/mul, reduce, MAC add, then pure delay
// out to LAT stages. All stages move together on en.
module m31_vec_lane
    import m31_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en,
    input  m31_t    a,
    input  m31_t    b,
    input  m31_t    c,
    input  m31_op_e op_s1,
    input  m31_op_e op_s2,
    input  m31_op_e op_s3,
    output m31_t    res
);

    m31_opnd_t          s1;
    logic [61:0]        raw2;
    logic [61:0]        raw2_d;
    m31_t               c2;
    m31_t               r3;
    m31_t               r3_d;
    m31_t               c3;
    m31_t               r4_d;
    logic [LAT:4][30:0] dly;

    // SUB uses ~b = p - b, so a operand equal to p still behaves as 0.
    always_comb begin
        raw2_d = '0;
        case (op_s1)
            OP_MUL, OP_MAC: raw2_d = {31'b0, s1.a} * {31'b0, s1.b};
            OP_SUB:         raw2_d = {30'b0, {1'b0, s1.a} + {1'b0, ~s1.b}};
            default:        raw2_d = {30'b0, {1'b0, s1.a} + {1'b0, s1.b}};
        endcase
    end

    always_comb begin
        r3_d = '0;
        if (op_s2 inside {OP_MUL, OP_MAC})
            r3_d = m31_fold62(raw2);
        else
            r3_d = m31_fold32(raw2[31:0]);
    end

    always_comb begin
        r4_d = r3;
        if (op_s3 == OP_MAC)
            r4_d = m31_fold32({1'b0, r3} + {1'b0, c3});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= '0;
            raw2 <= '0;
            c2   <= '0;
            r3   <= '0;
            c3   <= '0;
            dly  <= '0;
        end else if (en) begin
            s1     <= '{a: a, b: b, c: c};
            raw2   <= raw2_d;
            c2     <= s1.c;
            r3     <= r3_d;
            c3     <= c2;
            dly[4] <= r4_d;
            for (int i = 5; i <= LAT; i++)
                dly[i] <= dly[i-1];
        end
    end

    assign res = dly[LAT];

endmodule

// File: rtl/m31_vec_alu.sv
// Multi-lane pipelined M31 ADD/SUB/MUL/MAC unit with valid/ready handshake.
// Owns the valid/op/tag pipeline; lanes carry only data.
module m31_vec_alu
    import m31_pkg::*;
#(
    parameter int LANES = 16,
    parameter int LAT   = 4,
    parameter int TAG_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [LANES*31-1:0]   in_a,
    input  logic [LANES*31-1:0]   in_b,
    input  logic [LANES*31-1:0]   in_c,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*31-1:0]   out_res,
    output logic [TAG_W-1:0]      out_tag
);

    logic [LAT:1]             vld_pipe;
    logic [LAT:1][TAG_W-1:0]  tag_pipe;
    logic [3:1][1:0]          op_pipe;
    logic                     stall;
    logic                     adv;

    // A held output freezes the whole pipe; in_ready never looks at in_valid.
    assign stall     = vld_pipe[LAT] && !out_ready;
    assign adv       = !stall;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[LAT];
    assign out_tag   = tag_pipe[LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
            op_pipe  <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[LAT-1:1], in_valid};
            tag_pipe <= {tag_pipe[LAT-1:1], in_tag};
            op_pipe  <= {op_pipe[2:1], in_op};
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        m31_vec_lane #(
            .LAT (LAT)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (adv),
            .a     (in_a[31*i +: 31]),
            .b     (in_b[31*i +: 31]),
            .c     (in_c[31*i +: 31]),
            .op_s1 (m31_op_e'(op_pipe[1])),
            .op_s2 (m31_op_e'(op_pipe[2])),
            .op_s3 (m31_op_e'(op_pipe[3])),
            .res   (out_res[31*i +: 31])
        );
    end

endmodule

// File: tb/tb_m31_vec_alu.sv
// Scoreboard bench for m31_vec_alu: a stimulus thread queues reference results
// computed with plain modular arithmetic, a negedge monitor pops and compares.
module tb_m31_vec_alu;

    localparam int LANES = 16;
    localparam int LAT   = 4;
    localparam int TAG_W = 8;
    localparam int W     = LANES * 31;
    localparam longint unsigned P = 64'h7FFF_FFFF;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_op = '0;
    logic [W-1:0]     in_a = '0, in_b = '0, in_c = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     out_res;
    logic [TAG_W-1:0] out_tag;

    typedef struct {
        logic [W-1:0]     res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t             exp_q[$];
    int               total = 0;
    int               passed = 0;
    int               cyc = 0;
    int               last_pop = -10;
    int               streak = 0;
    bit               prev_stall = 1'b0;
    logic [W-1:0]     prev_res = '0;
    logic [TAG_W-1:0] prev_tag = '0;
    logic [W-1:0]     va, vb, vc;
    bit               done = 1'b0;

    m31_vec_alu #(.LANES(LANES), .LAT(LAT), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: reduce operands mod p, then the field operation mod p.
    function automatic logic [30:0] ref_lane(input logic [1:0] op, input longint unsigned a,
                                             input longint unsigned b, input longint unsigned c);
        longint unsigned r;
        a = a % P; b = b % P; c = c % P;
        case (op)
            2'd0:    r = (a + b) % P;
            2'd1:    r = (a + P - b) % P;
            2'd2:    r = (a * b) % P;
            default: r = ((a * b) % P + c) % P;
        endcase
        return r[30:0];
    endfunction

    function automatic logic [W-1:0] model_vec(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic [W-1:0] c);
        logic [W-1:0] r = '0;
        for (int i = 0; i < LANES; i++)
            r[31*i +: 31] = ref_lane(op, a[31*i +: 31], b[31*i +: 31], c[31*i +: 31]);
        return r;
    endfunction

    function automatic logic [30:0] rand_m31();
        case ($urandom_range(0, 7))
            0:       return 31'h7FFFFFFF;
            1:       return 31'h7FFFFFFE;
            2:       return 31'h0;
            3:       return 31'h1;
            default: return 31'($urandom);
        endcase
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] r = '0;
        for (int i = 0; i < LANES; i++) r[31*i +: 31] = rand_m31();
        return r;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [TAG_W-1:0] tag);
        bit ok = 1'b0;
        int n = 0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_c = c; in_tag = tag;
        while (!ok) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); n++;
            if (!ok && n > 200) begin
                $display("FAIL accept_timeout: got in_ready 0 for %0d cycles expected 1", n);
                $fatal(1);
            end
        end
        exp_q.push_back('{res: model_vec(op, a, b, c), tag: tag});
        #1 in_valid = 1'b0;
    endtask

    task automatic lat_check(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        check(name, W'(n), W'(LAT));
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin @(posedge clk); n++; end
        check(name, W'(exp_q.size()), W'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin : mon
            exp_t e;
            check("in_ready", W'(in_ready), W'(!(out_valid && !out_ready)));
            if (prev_stall) begin
                check("hold_res", out_res, prev_res);
                check("hold_tag", W'(out_tag), W'(prev_tag));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_output: got tag %0d expected no output", out_tag);
                end else begin
                    e = exp_q.pop_front();
                    check("res", out_res, e.res);
                    check("tag", W'(out_tag), W'(e.tag));
                end
                streak   <= (cyc == last_pop + 1) ? streak + 1 : 1;
                last_pop <= cyc;
            end
            prev_stall <= out_valid && !out_ready;
            prev_res   <= out_res;
            prev_tag   <= out_tag;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        #1;
        check("rst_out_valid", W'(out_valid), W'(1'b0));
        check("rst_out_res", out_res, '0);
        check("rst_out_tag", W'(out_tag), W'(0));
        check("rst_in_ready", W'(in_ready), W'(1'b1));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD wrap to 0, P as zero operand, plus latency from an empty pipe
        va = rand_vec(); vb = rand_vec(); vc = rand_vec();
        va[30:0] = 31'h7FFFFFFE; vb[30:0] = 31'h1;
        va[61:31] = 31'h7FFFFFFF; vb[61:31] = 31'h5;
        send(2'd0, va, vb, vc, 8'hA0);
        lat_check("lat_add");

        va = rand_vec(); vb = rand_vec();
        va[30:0] = 31'h0; vb[30:0] = 31'h1;
        va[61:31] = 31'h5; vb[61:31] = 31'h7FFFFFFF;
        send(2'd1, va, vb, vc, 8'hA1);

        va = '0; vb = rand_vec();
        va[30:0] = 31'h2E413A1F; vb[30:0] = 31'h16332D59;
        va[61:31] = 31'h7FFFFFFE; vb[61:31] = 31'h7FFFFFFE;
        send(2'd2, va, vb, vc, 8'hA2);

        // lane 1: 2*4 + (p-3) = p+5 -> 5
        va = rand_vec(); vb = rand_vec(); vc = rand_vec();
        va[30:0] = 31'h7FFFFFFE; vb[30:0] = 31'h7FFFFFFE; vc[30:0] = 31'h7FFFFFFE;
        va[61:31] = 31'h2; vb[61:31] = 31'h4; vc[61:31] = 31'h7FFFFFFC;
        send(2'd3, va, vb, vc, 8'hA3);
        drain("drain_directed");

        for (int t = 0; t < 8; t++)
            send(2'(t % 4), rand_vec(), rand_vec(), rand_vec(), 8'(t));
        drain("drain_b2b");
        check("b2b_streak", W'(streak), W'(8));

        fork
            begin
                for (int t = 0; t < 10; t++)
                    send(2'($urandom_range(0, 3)), rand_vec(), rand_vec(), rand_vec(), 8'(16 + t));
            end
            begin
                int n = 0;
                int lo = 0;
                do begin @(negedge clk); n++; end while (!out_valid && n < 50);
                @(posedge clk); #1 out_ready = 1'b0;
                repeat (3) begin @(negedge clk); if (!in_ready) lo++; end
                @(posedge clk); #1 out_ready = 1'b1;
                check("bp_in_ready_low", W'(lo), W'(3));
            end
        join
        drain("drain_bp");

        out_ready = 1'b0;
        for (int t = 0; t < 3; t++)
            send(2'($urandom_range(0, 3)), rand_vec(), rand_vec(), rand_vec(), 8'(32 + t));
        repeat (LAT - 3) @(posedge clk);
        #2;
        check("pre_rst_valid", W'(out_valid), W'(1'b1));
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_out_valid", W'(out_valid), W'(1'b0));
        check("midrst_out_res", out_res, '0);
        check("midrst_out_tag", W'(out_tag), W'(0));
        @(posedge clk); #2 rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        begin
            int seen = 0;
            repeat (6) begin @(negedge clk); if (out_valid) seen++; end
            check("no_stale_after_rst", W'(seen), W'(0));
        end
        @(posedge clk); #1;
        send(2'd2, rand_vec(), rand_vec(), rand_vec(), 8'h55);
        lat_check("lat_after_rst");
        drain("drain_rst");

        done = 1'b0;
        fork
            begin
                for (int t = 0; t < 60; t++) begin
                    send(2'($urandom_range(0, 3)), rand_vec(), rand_vec(), rand_vec(), 8'(64 + t));
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
                    #0;
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        @(posedge clk); #1 out_ready = 1'b1;
        drain("drain_random");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
